bit_unstuff: RTL

Receive-side bit unstuffer for the USB serial path. It sits between the NRZI decoder and the receive CRC checker / SIPO register. After every run of MAX_ONES consecutive 1s it removes the stuffed 0 the transmitter inserted. It flags a stuffing violation if a 1 appears where the stuffed 0 belongs, and counts payload bits per packet.

---
 rtl/usb_pkg.sv | 12 +
 rtl/bit_unstuff.sv | 107 ++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions: bit-stuffing run length and unstuffer states.
package usb_pkg;

  localparam int USB_MAX_ONES = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR
  } unstuff_state_t;

endpackage

// File: rtl/bit_unstuff.sv
// Receive bit unstuffer: drops the stuffed 0 after MAX_ONES ones, flags violations, counts payload bits.
// Latency 1 cycle (all outputs registered); no backpressure, pause tells CRC/SIPO to hold on a dropped bit.
// Optional UNSTUFF_EOP_CHECK_EN: an EOP arriving while a stuffed 0 is still owed raises stuff_err.
module bit_unstuff
  import usb_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             endp,
  input  logic             in_valid,
  input  logic             s_in,
  output logic             s_out,
  output logic             out_valid,
  output logic             pause,
  output logic             stuff_err,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int ONES_W = $clog2(MAX_ONES + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MAX_ONES);

  unstuff_state_t    state, state_nxt;
  logic [ONES_W-1:0] ones_cnt, ones_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              s_out_nxt, out_valid_nxt, pause_nxt, err_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      s_out     <= 1'b0;
      out_valid <= 1'b0;
      pause     <= 1'b0;
      stuff_err <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ones_cnt  <= ones_nxt;
      s_out     <= s_out_nxt;
      out_valid <= out_valid_nxt;
      pause     <= pause_nxt;
      stuff_err <= err_nxt;
      done      <= done_nxt;
      bit_cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ones_nxt      = ones_cnt;
    cnt_nxt       = bit_cnt;
    err_nxt       = stuff_err;
    s_out_nxt     = 1'b0;
    out_valid_nxt = 1'b0;
    pause_nxt     = 1'b0;
    done_nxt      = 1'b0;

    // start beats endp and any bit in the same cycle, from every state
    if (start) begin
      state_nxt = ACTIVE;
      ones_nxt  = '0;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          if (endp) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            ones_nxt  = '0;
`ifdef UNSTUFF_EOP_CHECK_EN
            if (ones_cnt == ONES_MAX) err_nxt = 1'b1;
`endif
          end else if (in_valid) begin
            if (ones_cnt != ONES_MAX) begin
              out_valid_nxt = 1'b1;
              s_out_nxt     = s_in;
              if (bit_cnt != '1) cnt_nxt = bit_cnt + 1'b1;
              ones_nxt = s_in ? ones_cnt + 1'b1 : '0;
            end else if (!s_in) begin
              pause_nxt = 1'b1;
              ones_nxt  = '0;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ERR;
            end
          end
        end
        ERR: begin
          if (endp) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            ones_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
